recip_table_loader: RTL
=======================

# recip_table_loader

Initiator side of the reciprocal engine handshake. Accepts a stream of N signed 8-bit diagonal coefficients, sends each one to the `reciprocal` engine and collects its S1.30 result. Results go into an N-entry table that the Gauss-Seidel datapath reads by index. The block also owns the engine's per-request reset, because the engine stays in its output state until it is reset.

## Interface
Parameters:
- `N`, 16: number of coefficients/table entries
- `IDX_W`, 4: index width, equal to clog2(N)
- `TIMEOUT`, 31: maximum cycles spent waiting for an engine response

Ports:
- `i_clk` in 1: single clock
- `i_reset` in 1: synchronous, active-high reset
- `i_start` in 1: one-cycle pulse that begins a load; honoured only in IDLE/DONE
- `i_in_valid` in 1: coefficient valid
- `o_in_ready` out 1: coefficient accepted when valid and ready are both high
- `i_in_data` in 8: signed coefficient
- `o_rcp_reset` out 1: engine reset, equal to `i_reset` OR (state==RST)
- `o_rcp_valid` out 1: engine request, held high for the whole REQ state
- `o_rcp_divisor` out 8: latched coefficient, stable from RST through WRITE
- `i_rcp_valid` in 1: engine result valid
- `i_rcp_quotient` in 32: engine result, S1.30
- `i_rd_addr` in IDX_W: table read index
- `o_rd_data` out 32: registered read data, 1-cycle latency
- `o_done` out 1: high in DONE
- `o_zero_div` out 1: sticky; set when a zero coefficient is seen
- `o_err` out 1: sticky; set when the engine times out

## Operation
- States: IDLE, ACCEPT, RST, REQ, WRITE, DONE.
- IDLE: on `i_start`, clear idx, `o_zero_div` and `o_err`, then go to ACCEPT.
- ACCEPT: `o_in_ready`=1.
  - On handshake, latch `i_in_data` into the divisor register.
  - Data 0: write value 0, set `o_zero_div`, go to WRITE. The engine is not touched.
  - Otherwise go to RST.
- RST: `o_rcp_reset`=1 for exactly one cycle, then go to REQ. The wait counter is cleared here.
- REQ: `o_rcp_valid`=1, and the wait counter increments each cycle.
  - On `i_rcp_valid`, capture `i_rcp_quotient` and go to WRITE.
  - If the counter reaches TIMEOUT without a response, capture 0, set `o_err`, go to WRITE.
  - `i_rcp_valid` and timeout in the same cycle: the response wins.
- WRITE: write the captured value to `table[idx]`.
  - If idx==N-1, go to DONE. Otherwise increment idx and go to ACCEPT.
- DONE: `o_done`=1. `i_start` restarts the load; the table contents are kept until overwritten.
- `i_start` in any other state is ignored.
- `i_rcp_valid` outside REQ is ignored.
- Sign handling belongs to the engine; results are stored unmodified.
- Reads are legal in every state. A read of the entry being written in the same cycle returns the old value.

## Timing
- Reset values:
  - state IDLE, idx 0
  - `o_in_ready`, `o_rcp_valid`, `o_done`, `o_zero_div`, `o_err` all 0
  - `o_rcp_divisor` 0, `o_rd_data` 0
  - table entries all 0
  - `o_rcp_reset`=1 while `i_reset`=1
- Reset mid-operation: on the next edge, return to IDLE with the reset values above. The engine is reset in the same cycle through `o_rcp_reset`.
- Per nonzero entry, L = engine response cycles: 1 (accept) + 1 (RST) + L (REQ, including the response cycle) + 1 (WRITE).
- Per zero entry: 2 cycles.
- Back-to-back input: `o_in_ready` is low from RST through WRITE; the earliest next accept is the cycle after WRITE.
- `o_done` rises on the cycle after the last WRITE.
- A table write is visible to a read issued on the next cycle; data appears one cycle after that read.

## Structure
- Shared package, `gs_pkg`:
  - state enum
  - result width 32, coefficient width 8
  - `RCP_ONE` = 32'h4000_0000
- Sub-module `recip_table`: N×32 register file with one write port and one registered read port, synchronously reset to 0.
- The FSM, divisor latch, wait counter and sticky flags stay in the top module.

## Test plan
- Real engine, N=4, inputs 1, 2, 4, 64: table reads back 0x4000_0000, 0x2000_0000, 0x1000_0000, 0x0100_0000. `o_done`=1, both flags 0.
- Inputs 3, 0, 5, 7: entry 1 is 0 and `o_zero_div`=1, with no `o_rcp_valid` pulse for entry 1. Entries 0 and 2 are within 2^-20 of 1/3 and 1/5 respectively.
- Engine model that never responds: each entry reads 0 after exactly TIMEOUT REQ cycles, `o_err`=1, and the load still reaches DONE.
- Engine model with fixed 5-cycle latency, gaps of 0–3 cycles in `i_in_valid`: `o_in_ready` is low during RST/REQ/WRITE, `o_rcp_divisor` is stable throughout, and all N entries are correct.
- Assert `i_reset` during REQ of entry 2: the next cycle shows IDLE reset values and `o_rcp_reset`=1. A fresh `i_start` then loads all entries correctly.
- In DONE, pulse `i_start` with a new set of inputs: flags clear, entries are overwritten, and `i_start` pulsed mid-load has no effect.

Source files
------------

// File: rtl/gs_pkg.sv
// Shared types and constants for the reciprocal table loader and its S1.30 result table.
package gs_pkg;
  localparam int RES_W  = 32;
  localparam int COEF_W = 8;

  // 1.0 in S1.30.
  localparam logic [RES_W-1:0] RCP_ONE = 32'h4000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_RST,
    ST_REQ,
    ST_WRITE,
    ST_DONE
  } state_t;
endpackage

// File: rtl/recip_table.sv
// N x 32 result table: one write port, one registered read port (1-cycle latency, never stalls).
// A read of the entry being written in the same cycle returns the old contents.
module recip_table
  import gs_pkg::*;
#(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_addr,
  input  logic [RES_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0] i_rd_addr,
  output logic [RES_W-1:0] o_rd_data
);
  logic [RES_W-1:0] mem_q [N];
  logic [RES_W-1:0] mem_d [N];
  logic [RES_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    mem_d = mem_q;
    if (i_wr_en) begin
      mem_d[i_wr_addr] = i_wr_data;
    end
    rd_data_d = mem_q[i_rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign o_rd_data = rd_data_q;
endmodule

// File: rtl/recip_table_loader.sv
// Feeds N coefficients to the reciprocal engine and tables the results; per entry 3+L cycles (2 if zero).
// Input is back-pressured (o_in_ready low) from engine reset until the table write completes.
module recip_table_loader
  import gs_pkg::*;
#(
  parameter int N       = 16,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [COEF_W-1:0] i_in_data,
  output logic              o_rcp_reset,
  output logic              o_rcp_valid,
  output logic [COEF_W-1:0] o_rcp_divisor,
  input  logic              i_rcp_valid,
  input  logic [RES_W-1:0]  i_rcp_quotient,
  input  logic [IDX_W-1:0]  i_rd_addr,
  output logic [RES_W-1:0]  o_rd_data,
  output logic              o_done,
  output logic              o_zero_div,
  output logic              o_err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [COEF_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RES_W-1:0]    val_q, val_d;
  logic                zero_q, zero_d;
  logic                err_q, err_d;
  logic                wr_en;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    zero_d  = zero_q;
    err_d   = err_q;
    wr_en   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          idx_d   = '0;
          zero_d  = 1'b0;
          err_d   = 1'b0;
          state_d = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (i_in_valid) begin
          div_d = i_in_data;
          // A zero divisor never reaches the engine; its entry is tabled as 0.
          if (i_in_data == '0) begin
            val_d   = '0;
            zero_d  = 1'b1;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RST;
          end
        end
      end
      ST_RST: begin
        cnt_d   = '0;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        // cnt_q counts completed REQ cycles, so this is the TIMEOUT-th one; a response still wins.
        if (i_rcp_valid) begin
          val_d   = i_rcp_quotient;
          state_d = ST_WRITE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          val_d   = '0;
          err_d   = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_en = 1'b1;
        if (idx_q == IDX_W'(N - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_ACCEPT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  // The engine holds its result until reset, so every request is preceded by a one-cycle reset.
  assign o_rcp_reset   = i_reset | (state_q == ST_RST);
  assign o_rcp_valid   = (state_q == ST_REQ);
  assign o_rcp_divisor = div_q;
  assign o_in_ready    = (state_q == ST_ACCEPT);
  assign o_done        = (state_q == ST_DONE);
  assign o_zero_div    = zero_q;
  assign o_err         = err_q;

  recip_table #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_table (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (wr_en),
    .i_wr_addr (idx_q),
    .i_wr_data (val_q),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data)
  );
endmodule
